// File: rtl/pipe_field_pkg.sv
// Shared types and screen constants for the pipe field and its gap calculator.
package pipe_field_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_e;

  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;
  localparam int OFF_X    = 641;  // parked x for empty slots
  localparam int OFF_Y    = 481;  // parked y for empty slots
  localparam int Y_MIN    = 8;    // highest allowed upper-pipe bottom
  localparam int Y_MAX    = 472;  // lowest allowed lower-pipe top

endpackage

// File: rtl/pipe_field_if.sv
// Control inputs and packed per-slot pipe outputs of the pipe field.
// master drives start/stop/pipe_length; slave (pipe_field) drives the rest.
interface pipe_field_if #(
  parameter int NUM_PIPES = 4
);
  logic                   start;
  logic                   stop;
  logic [9:0]             pipe_length;
  logic [NUM_PIPES-1:0]   pipe_valid;
  logic [NUM_PIPES*10-1:0] x0;
  logic [NUM_PIPES*10-1:0] x1;
  logic [NUM_PIPES*9-1:0]  y0;
  logic [NUM_PIPES*9-1:0]  y1;
  logic                   score_pulse;
  logic                   running;

  modport master (
    output start, stop, pipe_length,
    input  pipe_valid, x0, x1, y0, y1, score_pulse, running
  );

  modport slave (
    input  start, stop, pipe_length,
    output pipe_valid, x0, x1, y0, y1, score_pulse, running
  );
endinterface

// File: rtl/pipe_gap_calc.sv
// Combinational gap placement: random length word -> lower-pipe top (y0)
// and upper-pipe bottom (y1), shifted as a whole to stay on screen.
// Optional feature macro: PIPE_FIELD_WIDE_GAP_EN (hold_len[8] selects 7x gap).
module pipe_gap_calc
  import pipe_field_pkg::*;
#(
  parameter int BIRD_SIZE = 15
) (
  input  logic [9:0] hold_len_i,
  output logic [8:0] y0_o,
  output logic [8:0] y1_o
);

  localparam logic signed [10:0] G_NARROW = 11'(4 * BIRD_SIZE);
  localparam logic signed [10:0] G_WIDE   = 11'(7 * BIRD_SIZE);
  localparam logic signed [10:0] Y_LO     = 11'(Y_MIN);
  localparam logic signed [10:0] Y_HI     = 11'(Y_MAX);

  logic signed [10:0] off, center, gap, y1_raw, y0_raw, y1_c, y0_c;
  logic               unused_len_bits;

  // Bit 7 never contributes; bit 8 only in the wide-gap build.
  assign unused_len_bits = ^hold_len_i[8:7];

  // Centre the gap around the offset, then slide it back inside the bounds.
  always_comb begin
    off    = {4'b0, hold_len_i[6:0]};
    center = hold_len_i[9] ? (11'sd240 + off) : (11'sd240 - off);
`ifdef PIPE_FIELD_WIDE_GAP_EN
    gap    = hold_len_i[8] ? G_WIDE : G_NARROW;
`else
    gap    = G_NARROW;
`endif
    y1_raw = center - (gap >>> 1);
    y0_raw = y1_raw + gap;
    y1_c   = y1_raw;
    y0_c   = y0_raw;
    if (y1_raw < Y_LO) begin
      y1_c = Y_LO;
      y0_c = Y_LO + gap;
    end else if (y0_raw > Y_HI) begin
      y0_c = Y_HI;
      y1_c = Y_HI - gap;
    end
    y1_o = y1_c[8:0];
    y0_o = y0_c[8:0];
  end

endmodule

// File: rtl/pipe_field.sv
// Multi-slot pipe spawner/scroller: spawns a pipe every SPACING steps into a
// round-robin slot, scrolls live pipes left once per 2^DIV_BITS cycles,
// retires them past x=0 and pulses score as a pipe's right edge passes BIRD_X.
// Optional feature macro: PIPE_FIELD_WIDE_GAP_EN (handled in pipe_gap_calc).
module pipe_field
  import pipe_field_pkg::*;
#(
  parameter int NUM_PIPES  = 4,
  parameter int PIPE_WIDTH = 20,
  parameter int BIRD_SIZE  = 15,
  parameter int BIRD_X     = 100,
  parameter int SPACING    = 200,
  parameter int DIV_BITS   = 20
) (
  input  logic         clk,
  input  logic         reset,
  pipe_field_if.slave  bus
);

  localparam int PTR_W = (NUM_PIPES > 1) ? $clog2(NUM_PIPES) : 1;
  localparam int CNT_W = $clog2(SPACING + 1);

  state_e              state_q, state_d;
  logic [DIV_BITS-1:0] div_q, div_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [9:0]          hold_q, hold_d;
  logic [NUM_PIPES-1:0] valid_q, valid_d;
  logic [9:0]          x0_q [NUM_PIPES];
  logic [9:0]          x0_d [NUM_PIPES];
  logic [9:0]          x1_q [NUM_PIPES];
  logic [9:0]          x1_d [NUM_PIPES];
  logic [8:0]          y0_q [NUM_PIPES];
  logic [8:0]          y0_d [NUM_PIPES];
  logic [8:0]          y1_q [NUM_PIPES];
  logic [8:0]          y1_d [NUM_PIPES];
  logic                score_q, score_d;
  logic                running_q;

  logic                step, spawn, restart;
  logic [8:0]          gap_y0, gap_y1;

  pipe_gap_calc #(.BIRD_SIZE(BIRD_SIZE)) u_gap (
    .hold_len_i (hold_q),
    .y0_o       (gap_y0),
    .y1_o       (gap_y1)
  );

  // Next-state: mode control, step/spawn scheduling and per-slot updates.
  always_comb begin
    // NOTE: every _d gets its hold value first, so no path through this block
    // leaves a variable unassigned and no latch is inferred.
    state_d  = state_q;
    div_d    = div_q;
    cnt_d    = cnt_q;
    wr_ptr_d = wr_ptr_q;
    hold_d   = hold_q;
    valid_d  = valid_q;
    x0_d     = x0_q;
    x1_d     = x1_q;
    y0_d     = y0_q;
    y1_d     = y1_q;
    score_d  = 1'b0;
    step     = 1'b0;
    spawn    = 1'b0;
    restart  = 1'b0;

    unique case (state_q)
      IDLE: begin
        hold_d = bus.pipe_length;
        if (bus.start) restart = 1'b1;
      end
      RUN: begin
        // Stop freezes everything this cycle, including a pending step/spawn.
        if (bus.stop) begin
          state_d = HALT;
        end else begin
          step  = &div_q;
          div_d = div_q + 1'b1;
          spawn = (cnt_q == CNT_W'(SPACING)) && !valid_q[wr_ptr_q];
        end
      end
      HALT: begin
        if (bus.start && !bus.stop) restart = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    if (step && (cnt_q != CNT_W'(SPACING))) cnt_d = cnt_q + 1'b1;

    for (int i = 0; i < NUM_PIPES; i++) begin
      // A slot being spawned is free now, so the step branch never touches it.
      if (step && valid_q[i]) begin
        if (x1_q[i] == 10'(BIRD_X)) score_d = 1'b1;
        if (x1_q[i] == 10'd0) begin
          valid_d[i] = 1'b0;
          x0_d[i]    = 10'(OFF_X);
          x1_d[i]    = 10'(OFF_X);
          y0_d[i]    = 9'(OFF_Y);
          y1_d[i]    = 9'(OFF_Y);
        end else begin
          x0_d[i] = x0_q[i] - 1'b1;
          x1_d[i] = x1_q[i] - 1'b1;
        end
      end
      if (spawn && (PTR_W'(i) == wr_ptr_q)) begin
        valid_d[i] = 1'b1;
        x0_d[i]    = 10'(SCREEN_W);
        x1_d[i]    = 10'(SCREEN_W + PIPE_WIDTH);
        y0_d[i]    = gap_y0;
        y1_d[i]    = gap_y1;
      end
    end

    if (spawn) begin
      wr_ptr_d = (wr_ptr_q == PTR_W'(NUM_PIPES - 1)) ? '0 : wr_ptr_q + 1'b1;
      cnt_d    = '0;
      hold_d   = bus.pipe_length;
    end

    // Start from IDLE or HALT: empty field, first spawn on the first RUN cycle.
    if (restart) begin
      state_d  = RUN;
      div_d    = '0;
      cnt_d    = CNT_W'(SPACING);
      wr_ptr_d = '0;
      hold_d   = bus.pipe_length;
      valid_d  = '0;
      for (int i = 0; i < NUM_PIPES; i++) begin
        x0_d[i] = 10'(OFF_X);
        x1_d[i] = 10'(OFF_X);
        y0_d[i] = 9'(OFF_Y);
        y1_d[i] = 9'(OFF_Y);
      end
    end
  end

  // State and slot registers with asynchronous reset to the off-screen field.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      div_q     <= '0;
      cnt_q     <= '0;
      wr_ptr_q  <= '0;
      hold_q    <= '0;
      valid_q   <= '0;
      score_q   <= 1'b0;
      running_q <= 1'b0;
      // NOTE: slot storage is a handful of flops, not a RAM, so each entry is
      // reset explicitly to give the off-screen values straight out of reset.
      for (int i = 0; i < NUM_PIPES; i++) begin
        x0_q[i] <= 10'(OFF_X);
        x1_q[i] <= 10'(OFF_X);
        y0_q[i] <= 9'(OFF_Y);
        y1_q[i] <= 9'(OFF_Y);
      end
    end else begin
      // NOTE: non-blocking so every flop samples the pre-edge values.
      state_q   <= state_d;
      div_q     <= div_d;
      cnt_q     <= cnt_d;
      wr_ptr_q  <= wr_ptr_d;
      hold_q    <= hold_d;
      valid_q   <= valid_d;
      score_q   <= score_d;
      running_q <= (state_d == RUN);
      for (int i = 0; i < NUM_PIPES; i++) begin
        x0_q[i] <= x0_d[i];
        x1_q[i] <= x1_d[i];
        y0_q[i] <= y0_d[i];
        y1_q[i] <= y1_d[i];
      end
    end
  end

  assign bus.pipe_valid  = valid_q;
  assign bus.score_pulse = score_q;
  assign bus.running     = running_q;

  for (genvar g = 0; g < NUM_PIPES; g++) begin : g_out
    assign bus.x0[10*g +: 10] = x0_q[g];
    assign bus.x1[10*g +: 10] = x1_q[g];
    assign bus.y0[9*g +: 9]   = y0_q[g];
    assign bus.y1[9*g +: 9]   = y1_q[g];
  end

endmodule

// File: tb/tb_pipe_field.sv
// Bench for pipe_field: a cycle-level behavioural model compared every cycle,
// plus hand-computed literal expectations at key points of the scenario.
module tb_pipe_field;

  localparam int NP       = 2;
  localparam int PW       = 20;
  localparam int BS       = 15;
  localparam int BX       = 100;
  localparam int SPACING  = 100;
  localparam int DIV_BITS = 2;
  localparam int P        = 1 << DIV_BITS;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  pipe_field_if #(.NUM_PIPES(NP)) ifc ();

  pipe_field #(
    .NUM_PIPES(NP), .PIPE_WIDTH(PW), .BIRD_SIZE(BS), .BIRD_X(BX),
    .SPACING(SPACING), .DIV_BITS(DIV_BITS)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc.slave)
  );

  // Second gap calculator with a big bird so the clamping paths are reachable.
  logic [9:0] gl;
  logic [8:0] gy0, gy1;
  pipe_gap_calc #(.BIRD_SIZE(60)) gap_big (.hold_len_i(gl), .y0_o(gy0), .y1_o(gy1));

  int checks = 0;
  int errors = 0;
  bit check_en = 0;
  int pulses = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 30) $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [9:0] xf(input logic [NP*10-1:0] v, input int i);
    return v[10*i +: 10];
  endfunction

  function automatic logic [8:0] yf(input logic [NP*9-1:0] v, input int i);
    return v[9*i +: 9];
  endfunction

  // ---------------- behavioural model ----------------
  int m_st;  // 0 idle, 1 run, 2 halt
  int m_div, m_cnt, m_wp, m_hold;
  bit m_score;
  bit m_valid [NP];
  int m_x0 [NP], m_x1 [NP], m_y0 [NP], m_y1 [NP];

  task automatic gap_model(input int len, output int y0, output int y1);
    int off, center, g;
    off    = len % 128;
    center = ((len / 512) % 2 == 1) ? 240 + off : 240 - off;
    g      = 4 * BS;
`ifdef PIPE_FIELD_WIDE_GAP_EN
    if ((len / 256) % 2 == 1) g = 7 * BS;
`endif
    y1 = center - g / 2;
    y0 = y1 + g;
    if (y1 < 8) begin
      y1 = 8; y0 = 8 + g;
    end else if (y0 > 472) begin
      y0 = 472; y1 = 472 - g;
    end
  endtask

  task automatic model_clear(input int i);
    m_valid[i] = 0;
    m_x0[i] = 641; m_x1[i] = 641; m_y0[i] = 481; m_y1[i] = 481;
  endtask

  task automatic model_reset();
    m_st = 0; m_div = 0; m_cnt = 0; m_wp = 0; m_hold = 0; m_score = 0;
    for (int i = 0; i < NP; i++) model_clear(i);
  endtask

  task automatic model_restart();
    for (int i = 0; i < NP; i++) model_clear(i);
    m_st = 1; m_div = 0; m_cnt = SPACING; m_wp = 0; m_hold = ifc.pipe_length;
  endtask

  task automatic model_tick();
    bit step, spawn;
    int a, b;
    m_score = 0;
    case (m_st)
      0: begin
        m_hold = ifc.pipe_length;
        if (ifc.start) model_restart();
      end
      1: begin
        if (ifc.stop) m_st = 2;
        else begin
          step  = (m_div == P - 1);
          m_div = (m_div + 1) % P;
          spawn = (m_cnt == SPACING) && !m_valid[m_wp];
          if (step) begin
            for (int i = 0; i < NP; i++) begin
              if (m_valid[i]) begin
                if (m_x1[i] == BX) m_score = 1;
                if (m_x1[i] == 0) model_clear(i);
                else begin m_x0[i]--; m_x1[i]--; end
              end
            end
            if (m_cnt < SPACING) m_cnt++;
          end
          if (spawn) begin
            gap_model(m_hold, a, b);
            m_valid[m_wp] = 1;
            m_x0[m_wp] = 640; m_x1[m_wp] = 640 + PW;
            m_y0[m_wp] = a;   m_y1[m_wp] = b;
            m_wp   = (m_wp + 1) % NP;
            m_cnt  = 0;
            m_hold = ifc.pipe_length;
          end
        end
      end
      default: if (ifc.start && !ifc.stop) model_restart();
    endcase
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or posedge reset);
      if (reset) model_reset();
      else model_tick();
    end
  end

  // ---------------- per-cycle comparison ----------------
  task automatic compare();
    for (int i = 0; i < NP; i++) begin
      check($sformatf("valid[%0d]", i), ifc.pipe_valid[i], m_valid[i]);
      check($sformatf("x0[%0d]", i), xf(ifc.x0, i), m_x0[i] & 1023);
      check($sformatf("x1[%0d]", i), xf(ifc.x1, i), m_x1[i] & 1023);
      check($sformatf("y0[%0d]", i), yf(ifc.y0, i), m_y0[i]);
      check($sformatf("y1[%0d]", i), yf(ifc.y1, i), m_y1[i]);
    end
    check("score_pulse", ifc.score_pulse, m_score);
    check("running", ifc.running, m_st == 1);
  endtask

  initial forever begin
    @(negedge clk);
    if (check_en) compare();
  end

  initial forever begin
    @(negedge clk);
    if (ifc.score_pulse === 1'b1) pulses++;
  end

  // ---------------- directed scenario ----------------
  initial begin
    int n;
    ifc.start = 0; ifc.stop = 0; ifc.pipe_length = '0;
    gl = '0;

    // Clamp behaviour of the gap calculator (bird 60 -> gap 240).
    #1;
    check("big_mid_y1", gy1, 120);
    check("big_mid_y0", gy0, 360);
    gl = 10'h0FF; #1;
    check("big_low_y1", gy1, 8);
    check("big_low_y0", gy0, 248);
    gl = 10'h2FF; #1;
    check("big_high_y1", gy1, 232);
    check("big_high_y0", gy0, 472);

    repeat (3) @(negedge clk);
    check("rst_valid", ifc.pipe_valid, 0);
    check("rst_x0", ifc.x0, {10'd641, 10'd641});
    check("rst_x1", ifc.x1, {10'd641, 10'd641});
    check("rst_y0", ifc.y0, {9'd481, 9'd481});
    check("rst_y1", ifc.y1, {9'd481, 9'd481});
    check("rst_score", ifc.score_pulse, 0);
    check("rst_running", ifc.running, 0);
    reset = 0;
    check_en = 1;

    // Start; hold_len captured at start gives the first gap.
    @(negedge clk); ifc.start = 1; ifc.pipe_length = 10'h000;
    @(negedge clk); ifc.start = 0; ifc.pipe_length = 10'h3FF;
    @(negedge clk);
    check("spawn0_valid", ifc.pipe_valid, 2'b01);
    check("spawn0_x0", xf(ifc.x0, 0), 640);
    check("spawn0_x1", xf(ifc.x1, 0), 660);
    check("spawn0_y1", yf(ifc.y1, 0), 210);
    check("spawn0_y0", yf(ifc.y0, 0), 270);
    check("spawn0_slot1_x0", xf(ifc.x0, 1), 641);
    ifc.pipe_length = 10'h0FF;

    // Second spawn after SPACING steps, using the all-ones word.
    n = 0;
    while (ifc.pipe_valid[1] !== 1'b1 && n < 2000) begin @(negedge clk); n++; end
    check("spawn1_seen", ifc.pipe_valid[1], 1);
    check("spawn1_slot0_x0", xf(ifc.x0, 0), 540);
`ifdef PIPE_FIELD_WIDE_GAP_EN
    check("spawn1_y1", yf(ifc.y1, 1), 315);
    check("spawn1_y0", yf(ifc.y0, 1), 420);
`else
    check("spawn1_y1", yf(ifc.y1, 1), 337);
    check("spawn1_y0", yf(ifc.y0, 1), 397);
`endif

    // First score pulse: slot0 right edge just passed the bird.
    n = 0;
    while (ifc.score_pulse !== 1'b1 && n < 3000) begin @(negedge clk); n++; end
    check("score1_seen", ifc.score_pulse, 1);
    check("score1_slot0_x1", xf(ifc.x1, 0), 99);

    // Slot0 retires; the deferred third spawn then lands back in slot0.
    n = 0;
    while (ifc.pipe_valid[0] !== 1'b0 && n < 1000) begin @(negedge clk); n++; end
    check("retire0", ifc.pipe_valid[0], 0);
    n = 0;
    while (ifc.pipe_valid[0] !== 1'b1 && n < 10) begin @(negedge clk); n++; end
    check("spawn2_slot0", ifc.pipe_valid, 2'b11);
    check("spawn2_x0", xf(ifc.x0, 0), 640);
    check("spawn2_y1", yf(ifc.y1, 0), 83);
    check("spawn2_y0", yf(ifc.y0, 0), 143);
    check("pulses_by_retire", pulses, 2);

    // Freeze the field.
    ifc.stop = 1;
    repeat (1000) @(negedge clk);
    check("halt_running", ifc.running, 0);
    check("halt_slot0_x0", xf(ifc.x0, 0), 640);
    check("halt_slot1_x0", xf(ifc.x0, 1), 79);
    check("halt_slot1_x1", xf(ifc.x1, 1), 99);

    // Restart from HALT: cleared field, fresh spawn in slot0.
    ifc.stop = 0; ifc.start = 1; ifc.pipe_length = 10'h000;
    @(negedge clk); ifc.start = 0;
    @(negedge clk);
    check("restart_valid", ifc.pipe_valid, 2'b01);
    check("restart_x0", xf(ifc.x0, 0), 640);
    check("restart_slot1_x0", xf(ifc.x0, 1), 641);
    check("restart_y1", yf(ifc.y1, 0), 210);
    check("restart_running", ifc.running, 1);

    // Asynchronous reset in the middle of a cycle.
    repeat (6) @(negedge clk);
    @(posedge clk); #1 reset = 1;
    #1;
    check("arst_valid", ifc.pipe_valid, 0);
    check("arst_x0", ifc.x0, {10'd641, 10'd641});
    check("arst_y1", ifc.y1, {9'd481, 9'd481});
    check("arst_running", ifc.running, 0);
    @(negedge clk); reset = 0;
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
